// File: rtl/command_pkg.sv
// Shared command/response encoding for the LED remote link.
// The command encoder and the remote-side decoder both build on these definitions.
package command_pkg;

    localparam int unsigned RGB_W    = 3;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned PREFIX_W = 5;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SET    = 2'b01,
        OP_TOGGLE = 2'b10,
        OP_RSVD   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_OK         = 2'b00,
        ST_MISMATCH   = 2'b01,
        ST_REMOTE_ERR = 2'b10,
        ST_TIMEOUT    = 2'b11
    } rsp_status_e;

    localparam logic [PREFIX_W-1:0] SET_PREFIX        = 5'b10000;
    localparam logic [PREFIX_W-1:0] TOGGLE_PREFIX     = 5'b01000;
    localparam logic [BYTE_W-1:0]   NOP_BYTE          = 8'h20;
    localparam logic [PREFIX_W-1:0] RSP_COLOUR_PREFIX = 5'b00000;
    localparam logic [PREFIX_W-1:0] RSP_ERROR_PREFIX  = 5'b11111;

    typedef struct packed {
        rsp_status_e       status;
        logic [BYTE_W-1:0] data;
    } rsp_t;

    // Wire byte for a host command; reserved opcode degrades to NOP.
    function automatic logic [BYTE_W-1:0] encode_cmd(input logic [1:0] op,
                                                     input logic [RGB_W-1:0] rgb);
        case (op)
            OP_SET:    encode_cmd = {SET_PREFIX, rgb};
            OP_TOGGLE: encode_cmd = {TOGGLE_PREFIX, rgb};
            default:   encode_cmd = NOP_BYTE;
        endcase
    endfunction

    // Colour the remote should report once it has executed the command.
    function automatic logic [RGB_W-1:0] predict_rgb(input logic [1:0] op,
                                                     input logic [RGB_W-1:0] rgb,
                                                     input logic [RGB_W-1:0] shadow);
        case (op)
            OP_SET:    predict_rgb = rgb;
            OP_TOGGLE: predict_rgb = shadow ^ rgb;
            default:   predict_rgb = shadow;
        endcase
    endfunction

endpackage

// File: rtl/command_encoder_if.sv
// Host command, UART send/receive and response signals of the command encoder.
interface command_encoder_if;
    import command_pkg::*;

    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [RGB_W-1:0]  cmd_rgb;
    logic              cmd_ready;
    logic [BYTE_W-1:0] snd_data;
    logic              snd_ready;
    logic              snd_busy;
    logic [BYTE_W-1:0] rcv_data;
    logic              rcv_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [BYTE_W-1:0] rsp_data;
    logic [RGB_W-1:0]  rsp_rgb;

    modport master (
        output cmd_valid, cmd_op, cmd_rgb, snd_busy, rcv_data, rcv_ready,
        input  cmd_ready, snd_data, snd_ready, rsp_valid, rsp_status, rsp_data, rsp_rgb
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rgb, snd_busy, rcv_data, rcv_ready,
        output cmd_ready, snd_data, snd_ready, rsp_valid, rsp_status, rsp_data, rsp_rgb
    );

endinterface

// File: rtl/response_timer.sv
// Clearable up-counter that flags the last cycle of the response window.
module response_timer #(
    parameter int unsigned LIMIT_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (LIMIT_CYCLES > 1) ? $clog2(LIMIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q;

    // Saturate at LAST so a stalled consumer never sees the count wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= (LAST == '0);
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == LAST);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/command_encoder.sv
// Sends one encoded LED command over the UART, waits for the remote's colour
// report and classifies it against a locally tracked shadow colour.
module command_encoder
    import command_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset,
    command_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_SEND_WAIT = 3'd2,
        S_RESP_WAIT = 3'd3,
        S_REPORT    = 3'd4
    } state_e;

    localparam logic [RGB_W-1:0] SHADOW_RST = 3'b011;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] cmd_byte_q, cmd_byte_d;
    logic [RGB_W-1:0]  pred_q, pred_d;
    logic [RGB_W-1:0]  shadow_q, shadow_d;
    logic              seen_busy_q, seen_busy_d;
    logic              have_rsp_q, have_rsp_d;
    logic [BYTE_W-1:0] rcv_byte_q, rcv_byte_d;
    logic              snd_ready_q, snd_ready_d;
    logic [BYTE_W-1:0] snd_data_q, snd_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_t              rsp_q, rsp_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic              timer_clr, timer_en, timer_expired;
    logic [BYTE_W-1:0] rsp_byte_c;
    logic              got_rsp_c;

    response_timer #(.LIMIT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // A reply captured during SEND_WAIT takes precedence over the live receiver.
    assign got_rsp_c  = have_rsp_q | bus.rcv_ready;
    assign rsp_byte_c = have_rsp_q ? rcv_byte_q : bus.rcv_data;

    always_comb begin
        state_d     = state_q;
        cmd_byte_d  = cmd_byte_q;
        pred_d      = pred_q;
        shadow_d    = shadow_q;
        seen_busy_d = seen_busy_q;
        have_rsp_d  = have_rsp_q;
        rcv_byte_d  = rcv_byte_q;
        rsp_d       = rsp_q;
        snd_ready_d = 1'b0;
        snd_data_d  = '0;
        rsp_valid_d = 1'b0;
        timer_clr   = (state_q != S_RESP_WAIT);
        timer_en    = (state_q == S_RESP_WAIT);

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_byte_d  = encode_cmd(bus.cmd_op, bus.cmd_rgb);
                    pred_d      = predict_rgb(bus.cmd_op, bus.cmd_rgb, shadow_q);
                    seen_busy_d = 1'b0;
                    have_rsp_d  = 1'b0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (!bus.snd_busy) begin
                    snd_ready_d = 1'b1;
                    snd_data_d  = cmd_byte_q;
                    state_d     = S_SEND_WAIT;
                end
            end
            S_SEND_WAIT: begin
                if (bus.rcv_ready && !have_rsp_q) begin
                    have_rsp_d = 1'b1;
                    rcv_byte_d = bus.rcv_data;
                end
                if (bus.snd_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = S_RESP_WAIT;
                end
            end
            S_RESP_WAIT: begin
                if (got_rsp_c) begin
                    rsp_d.data = rsp_byte_c;
                    if (rsp_byte_c[BYTE_W-1:RGB_W] == RSP_COLOUR_PREFIX) begin
                        rsp_d.status = (rsp_byte_c[RGB_W-1:0] == pred_q) ? ST_OK : ST_MISMATCH;
                        shadow_d     = rsp_byte_c[RGB_W-1:0];
                    end else begin
                        rsp_d.status = ST_REMOTE_ERR;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else if (timer_expired) begin
                    rsp_d.status = ST_TIMEOUT;
                    rsp_d.data   = '0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_byte_q  <= '0;
            pred_q      <= '0;
            shadow_q    <= SHADOW_RST;
            seen_busy_q <= 1'b0;
            have_rsp_q  <= 1'b0;
            rcv_byte_q  <= '0;
            snd_ready_q <= 1'b0;
            snd_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '{status: ST_OK, data: '0};
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_byte_q  <= cmd_byte_d;
            pred_q      <= pred_d;
            shadow_q    <= shadow_d;
            seen_busy_q <= seen_busy_d;
            have_rsp_q  <= have_rsp_d;
            rcv_byte_q  <= rcv_byte_d;
            snd_ready_q <= snd_ready_d;
            snd_data_q  <= snd_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.snd_ready  = snd_ready_q;
    assign bus.snd_data   = snd_data_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = rsp_q.status;
    assign bus.rsp_data   = rsp_q.data;
    assign bus.rsp_rgb    = shadow_q;

endmodule

// File: tb/tb_command_encoder.sv
// Scoreboard bench for command_encoder: a transmitter/remote model drives the
// UART side, expected bytes and responses are queued and checked on arrival.
module tb_command_encoder;
    import command_pkg::*;

    localparam int TO = 40;

    typedef struct {
        logic [1:0] st;
        logic [7:0] data;
        logic [2:0] rgb;
    } exp_rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_busy = 1'b0;
    logic hold_busy = 1'b0;
    bit   spam_on = 1'b0;
    bit   prev_snd = 1'b0;
    int   cyc = 0;
    int   rsp_cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [2:0] shadow_m = 3'b011;

    logic [7:0] exp_byte_q[$];
    exp_rsp_t   exp_rsp_q[$];

    command_encoder_if bus ();

    command_encoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.snd_busy = tx_busy | hold_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (spam_on) begin
            bus.cmd_valid = ~bus.cmd_valid;
            bus.cmd_op    = 2'b01;
            bus.cmd_rgb   = 3'b111;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        shadow_m = 3'b011;
    endtask

    // Byte and response monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_snd = 1'b0;
            end else begin
                if (prev_snd) begin
                    chk("snd_pulse_width", 32'(bus.snd_ready), 0);
                    chk("snd_data_clear", 32'(bus.snd_data), 0);
                end
                if (bus.snd_ready) begin
                    chk("snd_expected", 32'(exp_byte_q.size() != 0), 1);
                    if (exp_byte_q.size() != 0) chk("snd_data", 32'(bus.snd_data), 32'(exp_byte_q.pop_front()));
                end
                prev_snd = bus.snd_ready;
                if (bus.rsp_valid) begin
                    chk("rsp_expected", 32'(exp_rsp_q.size() != 0), 1);
                    if (exp_rsp_q.size() != 0) begin
                        exp_rsp_t e;
                        e = exp_rsp_q.pop_front();
                        chk("rsp_status", 32'(bus.rsp_status), 32'(e.st));
                        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                        chk("rsp_rgb", 32'(bus.rsp_rgb), 32'(e.rgb));
                        rsp_cyc = cyc;
                    end
                end
            end
        end
    end

    // One full transaction; rdelay counts cycles from busy release to the reply strobe.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] rgb,
                          input bit reply, input logic [7:0] rbyte, input int rdelay,
                          input bit early, input int prebusy, input bit spam, input int abort);
        logic [7:0] eb;
        logic [2:0] pred;
        exp_rsp_t   e;
        int         n;
        int         drop;
        int         exp_cyc;

        case (op)
            2'b01:   begin eb = {5'b10000, rgb}; pred = rgb; end
            2'b10:   begin eb = {5'b01000, rgb}; pred = shadow_m ^ rgb; end
            default: begin eb = 8'h20; pred = shadow_m; end
        endcase
        if (!reply) begin
            e = '{st: 2'd3, data: 8'h00, rgb: shadow_m};
        end else if (rbyte[7:3] == 5'b00000) begin
            e = '{st: (rbyte[2:0] == pred) ? 2'd0 : 2'd1, data: rbyte, rgb: rbyte[2:0]};
        end else begin
            e = '{st: 2'd2, data: rbyte, rgb: shadow_m};
        end
        exp_byte_q.push_back(eb);
        if (abort < 0) begin
            exp_rsp_q.push_back(e);
            shadow_m = e.rgb;
        end

        chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        hold_busy     = (prebusy > 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rgb   = rgb;
        tick();
        bus.cmd_valid = 1'b0;
        spam_on       = spam;

        n = 0;
        do begin
            tick();
            n++;
            if (!bus.snd_ready && n >= prebusy) hold_busy = 1'b0;
        end while (!bus.snd_ready && n < prebusy + 20);
        chk("send_latency", 32'(n), 32'(prebusy + 1));
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 0);

        tx_busy = 1'b1;
        tick();
        if (early) begin
            bus.rcv_data  = rbyte;
            bus.rcv_ready = 1'b1;
        end
        tick();
        bus.rcv_ready = 1'b0;
        tick();
        tx_busy = 1'b0;
        drop    = cyc;

        if (abort >= 0) begin
            repeat (abort) tick();
            spam_on       = 1'b0;
            bus.cmd_valid = 1'b0;
            reset         = 1'b1;
            repeat (3) tick();
            reset = 1'b0;
            chk("abort_snd_ready", 32'(bus.snd_ready), 0);
            chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
            tick();
            chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
            chk("abort_shadow", 32'(bus.rsp_rgb), 3);
            shadow_m = 3'b011;
            repeat (TO + 10) tick();
            return;
        end

        if (reply && !early) begin
            repeat (rdelay) tick();
            spam_on       = 1'b0;
            bus.cmd_valid = 1'b0;
            bus.rcv_data  = rbyte;
            bus.rcv_ready = 1'b1;
            tick();
            bus.rcv_ready = 1'b0;
        end else begin
            spam_on       = 1'b0;
            bus.cmd_valid = 1'b0;
        end

        n = 0;
        while (exp_rsp_q.size() != 0 && n < TO + 20) begin
            tick();
            n++;
        end
        chk("rsp_arrived", 32'(exp_rsp_q.size()), 0);
        exp_rsp_q.delete();
        exp_cyc = early ? drop + 2 : drop + 1 + (reply ? rdelay : TO);
        chk("rsp_latency", 32'(rsp_cyc), 32'(exp_cyc));
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_rgb   = 3'b000;
        bus.rcv_data  = 8'h00;
        bus.rcv_ready = 1'b0;

        do_reset();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_snd_ready", 32'(bus.snd_ready), 0);
        chk("rst_snd_data", 32'(bus.snd_data), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_status", 32'(bus.rsp_status), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_rgb", 32'(bus.rsp_rgb), 3);

        // Stray reply while idle must be dropped.
        bus.rcv_data  = 8'h07;
        bus.rcv_ready = 1'b1;
        tick();
        bus.rcv_ready = 1'b0;
        repeat (4) tick();
        chk("idle_rcv_ignored", 32'(bus.rsp_rgb), 3);

        //     op     rgb     rep  byte   dly  early pre spam abort
        do_cmd(2'b01, 3'b101, 1, 8'h05, 3,  0, 0, 0, -1);
        do_reset();
        tick();
        do_cmd(2'b10, 3'b010, 1, 8'h03, 3,  0, 0, 0, -1);
        do_cmd(2'b10, 3'b010, 1, 8'h01, 5,  0, 0, 0, -1);
        do_cmd(2'b01, 3'b001, 1, {RSP_ERROR_PREFIX, 3'b010}, 2, 0, 0, 0, -1);
        do_cmd(2'b00, 3'b110, 0, 8'h00, 0,  0, 0, 0, -1);
        do_cmd(2'b00, 3'b000, 1, 8'h01, TO, 0, 0, 0, -1);
        do_cmd(2'b11, 3'b111, 1, 8'h06, 0,  1, 0, 0, -1);
        do_cmd(2'b01, 3'b111, 1, 8'h07, 4,  0, 50, 1, -1);
        do_cmd(2'b10, 3'b100, 0, 8'h00, 0,  0, 0, 0, 6);
        do_cmd(2'b10, 3'b001, 1, 8'h02, 1,  0, 0, 0, -1);

        repeat (5) tick();
        chk("bytes_drained", 32'(exp_byte_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
